// File: rtl/cond_unit_if.sv
// rtl/cond_unit_if.sv - decoder-to-commit bundle for the conditional-execution stage
interface cond_unit_if #(parameter int CNT_W = 16);
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             Stall;
  logic             Flush;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic             CondEx;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] RetireCount;
  logic [CNT_W-1:0] SquashCount;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, RegW, MemW, Stall, Flush,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags, RetireCount, SquashCount
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, Stall, Flush,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags, RetireCount, SquashCount
  );
endinterface

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - NZCV flag register, condition check, strobe gating and retire/squash counters
module cond_unit #(
  parameter int CNT_W = 16
) (
  input logic        clk,
  input logic        reset,
  cond_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0]       flags_q;
  logic [CNT_W-1:0] retire_q;
  logic [CNT_W-1:0] squash_q;
  logic             n, z, c, v;
  logic             cond_ex;
  logic             commit;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    cond_ex = 1'b1;
    case (bus.Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      default: cond_ex = 1'b1;
    endcase
  end

  assign commit       = cond_ex & ~bus.Stall & ~bus.Flush;
  assign bus.PCSrc    = bus.PCS  & commit;
  assign bus.RegWrite = bus.RegW & commit;
  assign bus.MemWrite = bus.MemW & commit;
  assign bus.CondEx   = cond_ex;
  assign bus.Flags    = flags_q;
  assign bus.RetireCount = retire_q;
  assign bus.SquashCount = squash_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q  <= 4'b0000;
      retire_q <= '0;
      squash_q <= '0;
    end else begin
      if (commit) begin
        if (bus.FlagW[1]) flags_q[3:2] <= bus.ALUFlags[3:2];
        if (bus.FlagW[0]) flags_q[1:0] <= bus.ALUFlags[1:0];
      end
      // Stall counts nothing; otherwise exactly one counter advances, saturating.
      if (!bus.Stall) begin
        if (commit) begin
          if (retire_q != CNT_MAX) retire_q <= retire_q + CNT_W'(1);
        end else begin
          if (squash_q != CNT_MAX) squash_q <= squash_q + CNT_W'(1);
        end
      end
    end
  end

  // Strobes are ANDed with commit, so an unknown decoder strobe never leaks out when not committing.
  always_ff @(posedge clk) begin
    if (!reset && !commit)
      assert (!$isunknown({bus.PCSrc, bus.RegWrite, bus.MemWrite}));
  end

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - scoreboard bench for cond_unit with a reference flag/counter model
module tb_cond_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cond_unit_if #(.CNT_W(16)) bus16 ();
  cond_unit_if #(.CNT_W(2))  bus2 ();

  cond_unit #(.CNT_W(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));
  cond_unit #(.CNT_W(2))  dut2  (.clk(clk), .reset(reset), .bus(bus2.slave));

  typedef struct {
    logic       pcsrc;
    logic       regwrite;
    logic       memwrite;
    logic       condex;
    logic [3:0] flags;
    int         r16;
    int         s16;
    int         r2;
    int         s2;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [3:0] m_flags;
  int         m_r16, m_s16, m_r2, m_s2;

  localparam logic [3:0] EQ = 4'd0, NE = 4'd1, GE = 4'd10, LT = 4'd11,
                         GT = 4'd12, LE = 4'd13, AL = 4'd14;

  function automatic logic cond_pass(input logic [3:0] cnd, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cnd)
      0: return z;           1: return !z;
      2: return c;           3: return !c;
      4: return n;           5: return !n;
      6: return v;           7: return !v;
      8: return c && !z;     9: return !c || z;
      10: return n == v;     11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic int sat_inc(input int x, input int mx);
    return (x >= mx) ? mx : x + 1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic step(input logic [3:0] cnd, input logic [3:0] alu, input logic [1:0] fw,
                      input logic pcs, input logic regw, input logic memw,
                      input logic stl, input logic fl, input logic rst);
    exp_t e;
    logic ce, cm;
    @(negedge clk);
    reset = rst;
    bus16.Cond = cnd; bus16.ALUFlags = alu; bus16.FlagW = fw;
    bus16.PCS = pcs;  bus16.RegW = regw;    bus16.MemW = memw;
    bus16.Stall = stl; bus16.Flush = fl;
    bus2.Cond = cnd;  bus2.ALUFlags = alu;  bus2.FlagW = fw;
    bus2.PCS = pcs;   bus2.RegW = regw;     bus2.MemW = memw;
    bus2.Stall = stl; bus2.Flush = fl;
    ce = cond_pass(cnd, m_flags);
    cm = ce && !stl && !fl;
    e.pcsrc = pcs && cm;
    e.regwrite = regw && cm;
    e.memwrite = memw && cm;
    e.condex = ce;
    e.flags = m_flags;
    e.r16 = m_r16; e.s16 = m_s16; e.r2 = m_r2; e.s2 = m_s2;
    exp_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      m_flags = 4'b0000;
      m_r16 = 0; m_s16 = 0; m_r2 = 0; m_s2 = 0;
    end else begin
      if (cm) begin
        if (fw[1]) m_flags[3:2] = alu[3:2];
        if (fw[0]) m_flags[1:0] = alu[1:0];
      end
      if (!stl) begin
        if (cm) begin
          m_r16 = sat_inc(m_r16, 65535); m_r2 = sat_inc(m_r2, 3);
        end else begin
          m_s16 = sat_inc(m_s16, 65535); m_s2 = sat_inc(m_s2, 3);
        end
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("PCSrc",    32'(bus16.PCSrc),    32'(e.pcsrc));
        check("RegWrite", 32'(bus16.RegWrite), 32'(e.regwrite));
        check("MemWrite", 32'(bus16.MemWrite), 32'(e.memwrite));
        check("CondEx",   32'(bus16.CondEx),   32'(e.condex));
        check("Flags",    32'(bus16.Flags),    32'(e.flags));
        check("Retire16", 32'(bus16.RetireCount), e.r16);
        check("Squash16", 32'(bus16.SquashCount), e.s16);
        check("Flags2",   32'(bus2.Flags),     32'(e.flags));
        check("Retire2",  32'(bus2.RetireCount), e.r2);
        check("Squash2",  32'(bus2.SquashCount), e.s2);
      end
    end
  end

  initial begin : driver
    {bus16.Cond, bus16.ALUFlags, bus16.FlagW, bus16.PCS, bus16.RegW, bus16.MemW} = '0;
    {bus16.Stall, bus16.Flush} = '0;
    {bus2.Cond, bus2.ALUFlags, bus2.FlagW, bus2.PCS, bus2.RegW, bus2.MemW} = '0;
    {bus2.Stall, bus2.Flush} = '0;
    repeat (2) @(posedge clk);
    m_flags = 4'b0000;
    m_r16 = 0; m_s16 = 0; m_r2 = 0; m_s2 = 0;

    // reset state observed with EQ (fails on zero flags), then AL register write
    step(EQ, 4'h0, 2'b00, 0, 0, 0, 0, 0, 1);
    step(AL, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0);
    // Z set via AL, then EQ passes and NE squashes
    step(AL, 4'b0100, 2'b11, 0, 0, 0, 0, 0, 0);
    step(EQ, 4'h0, 2'b00, 0, 0, 1, 0, 0, 0);
    step(NE, 4'h0, 2'b00, 0, 0, 1, 0, 0, 0);
    // partial flag writes
    step(AL, 4'b1111, 2'b11, 0, 0, 0, 0, 0, 0);
    step(AL, 4'b0000, 2'b01, 0, 0, 0, 0, 0, 0);
    step(AL, 4'b0000, 2'b10, 0, 0, 0, 0, 0, 0);
    // failing conditional flag-setter leaves flags alone
    step(EQ, 4'b1111, 2'b11, 0, 1, 0, 0, 0, 0);
    // signed conditions with N=1,V=0 then N=1,V=1,Z=0
    step(AL, 4'b1000, 2'b11, 0, 0, 0, 0, 0, 0);
    step(GE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0);
    step(LT, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0);
    step(GT, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0);
    step(LE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0);
    step(AL, 4'b1001, 2'b11, 0, 0, 0, 0, 0, 0);
    step(GE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0);
    step(GT, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0);
    // stall+flush, then flush alone
    step(AL, 4'b0110, 2'b11, 1, 1, 1, 1, 1, 0);
    step(AL, 4'b0110, 2'b11, 1, 0, 0, 0, 1, 0);
    step(AL, 4'b0110, 2'b11, 1, 0, 0, 1, 0, 0);
    // saturation on the narrow counter, then reset mid-run
    for (int i = 0; i < 5; i++) step(AL, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0);
    step(AL, 4'b1111, 2'b11, 1, 1, 1, 0, 0, 1);
    step(EQ, 4'h0, 2'b00, 1, 1, 1, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 60) == 0));
    end
    @(negedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution stage that sits directly downstream of the instruction decoder. It holds the architectural NZCV flag register and evaluates the 4-bit condition field against the stored flags. It gates the decoder's PCS/RegW/MemW strobes into the committed PCSrc/RegWrite/MemWrite controls, and updates flags from the ALU under the decoder's two-bit FlagW mask. It also keeps saturating retire/squash counters for bring-up and debug.

## Interface
Parameters:
- CNT_W, 16, width of each saturating event counter (2..32).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- Cond  in  4  instruction condition field, Instr[31:28].
- ALUFlags  in  4  current ALU result flags {N,Z,C,V}.
- FlagW  in  2  from decoder; [1] enables N,Z write, [0] enables C,V write.
- PCS  in  1  from decoder; instruction writes PC.
- RegW  in  1  from decoder; instruction writes register file.
- MemW  in  1  from decoder; instruction writes data memory.
- Stall  in  1  hold; the instruction in this stage is not committed this cycle.
- Flush  in  1  kill; the instruction in this stage is discarded.
- PCSrc  out  1  committed PC write.
- RegWrite  out  1  committed register write.
- MemWrite  out  1  committed memory write.
- CondEx  out  1  condition passed against stored flags (ungated by Stall/Flush).
- Flags  out  4  stored {N,Z,C,V}.
- RetireCount  out  CNT_W  instructions committed.
- SquashCount  out  CNT_W  instructions discarded (flush or condition fail).

## Operation
- Flag register: Flags[3:2]=N,Z; Flags[1:0]=C,V. Reset value 4'b0000.
- CondEx is combinational from Cond and the stored Flags. It never uses ALUFlags.
  - 0000 EQ: Z. 0001 NE: ~Z.
  - 0010 CS: C. 0011 CC: ~C.
  - 0100 MI: N. 0101 PL: ~N.
  - 0110 VS: V. 0111 VC: ~V.
  - 1000 HI: C&~Z. 1001 LS: ~C|Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: ~Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1. 1111: treated as 1 (unconditional).
- Commit enable: commit = CondEx & ~Stall & ~Flush.
- Committed strobes: PCSrc = PCS & commit, RegWrite = RegW & commit, MemWrite = MemW & commit.
- Flag update on rising edge when commit:
  - If FlagW[1]: Flags[3:2] <= ALUFlags[3:2].
  - If FlagW[0]: Flags[1:0] <= ALUFlags[1:0].
  - Unselected bits hold.
- Counters, on the edge, only when ~Stall:
  - If commit: RetireCount++.
  - Else (Flush, or CondEx=0): SquashCount++.
  - Exactly one counter changes per non-stalled cycle.
- Counters saturate at 2^CNT_W-1 and never wrap. Reset value of both is 0.
- Stall dominates Flush for counting. Stall=1 with Flush=1 counts nothing, holds flags, and drives all strobes to 0.
- Reset dominates everything. Reset mid-sequence clears Flags and both counters on that edge. Strobes are combinational and are not forced by reset; with Flags=0, Cond=EQ evaluates to 0.
- Any Cond or FlagW value is legal; X on decoder outputs is not propagated when commit=0. A verification assertion checks this.

## Timing
- Zero-latency combinational paths:
  - Cond/Flags/PCS/RegW/MemW/Stall/Flush -> PCSrc/RegWrite/MemWrite.
  - Cond/Flags -> CondEx.
- A flag write is visible on Flags and CondEx in the cycle after the committing edge. Back-to-back dependent instructions see the previous instruction's flags.
- A failing conditional flag-setting instruction (CondEx=0) does not update flags.
- A counter increments one cycle after the qualifying cycle. Saturation holds from the cycle the count reaches max.

## Test plan
- Reset, then Cond=1110 (AL), RegW=1, no stall or flush -> RegWrite=1, Flags=0000. RetireCount reads 1 after the edge.
- Flags=0000; FlagW=11 with ALUFlags=0100, Cond=AL, commit -> next cycle Flags=0100. Then Cond=0000 (EQ), MemW=1 -> MemWrite=1. Then Cond=0001 (NE) -> MemWrite=0, SquashCount+1.
- Partial write: Flags=1111; FlagW=01 with ALUFlags=0000 -> Flags=1100. Then FlagW=10 with ALUFlags=0000 -> Flags=0000.
- Signed conditions: Flags N=1,V=0 -> GE=0, LT=1, GT=0, LE=1. Flags N=1,V=1,Z=0 -> GE=1, GT=1.
- Stall=1 and Flush=1 with Cond=AL, PCS=1, FlagW=11 -> PCSrc=0, Flags unchanged, both counters unchanged. Flush alone -> PCSrc=0, SquashCount+1.
- CNT_W=2: 5 committed AL instructions -> RetireCount sequence 1,2,3,3,3. Then assert reset mid-run -> Flags=0000 and both counters=0 on the next edge.
